regfile_wr_arbiter: RTL and testbench

Shares the single write port of the 32x32 register file among NREQ producers (ALU, load unit, CSR unit, ...).
Each producer uses a valid/ready handshake. The block grants one producer per cycle in round-robin order and registers the winning write onto the register-file write port (enable/rd/write).
It filters writes to x0 and reports which destination register is in flight.

---
 rtl/rfarb_pkg.sv | 21 ++
 rtl/regfile_wr_arbiter_rr_pick.sv | 35 +++
 rtl/regfile_wr_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wr_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rfarb_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
// Optional owner-lock mode is built when RFARB_LOCK_EN is defined.
package rfarb_pkg;

  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;
  localparam int NREQ_MAX = 8;

  typedef logic [2:0] id_t;

  typedef enum logic {
    ARB,
    LOCK
  } arb_state_t;

  // Round-robin successor of requester v among n requesters.
  function automatic id_t wrap_inc(id_t v, int n);
    return (int'(v) + 1 >= n) ? id_t'(0) : id_t'(v + 3'd1);
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import rfarb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   winner,
  output logic            any_valid
);

  always_comb begin
    int          idx;
    logic [IW-1:0] sel;
    // NOTE: every output gets a default before the loop so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    grant     = '0;
    winner    = '0;
    any_valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = IW'(idx);
      if (!any_valid && req[sel]) begin
        any_valid   = 1'b1;
        winner      = sel;
        grant[sel]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ producers.
// Define RFARB_LOCK_EN to add req_lock and the ARB/LOCK ownership FSM.
module regfile_wr_arbiter
  import rfarb_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int DW   = DW_DEF,
  parameter  int AW   = AW_DEF,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arb_en,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_rd,
  input  logic [NREQ*DW-1:0] req_data,
`ifdef RFARB_LOCK_EN
  input  logic [NREQ-1:0]    req_lock,
`endif
  output logic [NREQ-1:0]    req_ready,
  output logic               wr_enable,
  output logic [AW-1:0]      wr_rd,
  output logic [DW-1:0]      wr_data,
  output logic [IW-1:0]      grant_id,
  output logic [2**AW-1:0]   pending
);

  logic [NREQ-1:0] pick_req;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   next_ptr;
  logic            any_valid;
  logic            xfer;
  logic [AW-1:0]   win_rd;
  logic [DW-1:0]   win_data;

`ifdef RFARB_LOCK_EN
  arb_state_t    state;
  logic [IW-1:0] lock_id;

  // While locked, only the owner is visible to the picker.
  always_comb begin
    pick_req = req_valid;
    if (state == LOCK) pick_req = req_valid & (NREQ'(1) << lock_id);
  end
`else
  assign pick_req = req_valid;
`endif

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req       (pick_req),
    .ptr       (rr_ptr),
    .grant     (grant),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign req_ready = arb_en ? grant : '0;
  assign xfer      = arb_en & any_valid;
  assign win_rd    = AW'(req_rd >> (winner * AW));
  assign win_data  = DW'(req_data >> (winner * DW));
  assign next_ptr  = IW'(wrap_inc(id_t'(winner), NREQ));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr    <= '0;
      wr_enable <= 1'b0;
      wr_rd     <= '0;
      wr_data   <= '0;
      grant_id  <= '0;
    end else begin
      wr_enable <= xfer && (win_rd != '0);
      if (xfer) begin
        rr_ptr   <= next_ptr;
        wr_rd    <= win_rd;
        wr_data  <= win_data;
        grant_id <= winner;
      end
    end
  end

`ifdef RFARB_LOCK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ARB;
      lock_id <= '0;
    end else if (xfer) begin
      case (state)
        ARB: if (req_lock[winner]) begin
          state   <= LOCK;
          lock_id <= winner;
        end
        LOCK: if (!req_lock[winner]) state <= ARB;
        default: state <= ARB;
      endcase
    end
  end
`endif

  // Writes to x0 never raise wr_enable, so they never show as pending.
  always_comb begin
    pending = '0;
    if (wr_enable) pending[wr_rd] = 1'b1;
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: directed cases plus randomized traffic
// against a queue-based reference model.
module tb_regfile_wr_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 32;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    int            id;
  } beat_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               arb_en;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_rd;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               wr_enable;
  logic [AW-1:0]      wr_rd;
  logic [DW-1:0]      wr_data;
  logic [1:0]         grant_id;
  logic [2**AW-1:0]   pending;
`ifdef RFARB_LOCK_EN
  logic [NREQ-1:0]    req_lock;
  bit                 m_locked;
  int                 m_lock_id;
`endif

  int    n_total = 0;
  int    n_bad   = 0;
  int    m_ptr   = 0;
  beat_t exp_q[$];

  // Per-requester pending write for the random phase.
  bit            h_valid [NREQ];
  logic [AW-1:0] h_rd    [NREQ];
  logic [DW-1:0] h_data  [NREQ];

  regfile_wr_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .arb_en    (arb_en),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_data  (req_data),
`ifdef RFARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .wr_enable (wr_enable),
    .wr_rd     (wr_rd),
    .wr_data   (wr_data),
    .grant_id  (grant_id),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [DW-1:0] data);
    req_rd   = (req_rd & ~((NREQ*AW)'(5'h1f) << (i*AW))) | ((NREQ*AW)'(rd) << (i*AW));
    req_data = (req_data & ~((NREQ*DW)'(32'hffff_ffff) << (i*DW))) | ((NREQ*DW)'(data) << (i*DW));
  endtask

  // Called right after inputs are applied at a negedge: predicts the grant,
  // compares req_ready and queues the write the DUT must produce.
  task automatic issue(output int w);
    logic [NREQ-1:0] exp_ready;
    logic [AW-1:0]   rd;
    int              idx;
    #1;
    w = -1;
`ifdef RFARB_LOCK_EN
    if (m_locked) begin
      if (((req_valid >> m_lock_id) & 1) != 0) w = m_lock_id;
    end else
`endif
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (w < 0 && ((req_valid >> idx) & 1) != 0) w = idx;
    end
    if (!arb_en) w = -1;
    exp_ready = (w >= 0) ? (NREQ'(1) << w) : '0;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    if (w >= 0) begin
      rd = AW'(req_rd >> (w*AW));
      if (rd != '0) exp_q.push_back('{rd, DW'(req_data >> (w*DW)), w});
      m_ptr = (w + 1) % NREQ;
`ifdef RFARB_LOCK_EN
      if (m_locked) m_locked = ((req_lock >> w) & 1) != 0;
      else if (((req_lock >> w) & 1) != 0) begin
        m_locked  = 1'b1;
        m_lock_id = w;
      end
`endif
    end
  endtask

  // Monitor: every real register-file write must match the head of the queue.
  initial begin
    beat_t e;
    forever begin
      @(posedge clk);
      #1;
      if (wr_enable) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(wr_rd), 64'h0);
        end else begin
          e = exp_q.pop_front();
          check("wr_rd", 64'(wr_rd), 64'(e.rd));
          check("wr_data", 64'(wr_data), 64'(e.data));
          check("grant_id", 64'(grant_id), 64'(e.id));
          check("pending", 64'(pending), 64'(32'h1 << e.rd));
        end
      end else begin
        check("pending_idle", 64'(pending), 64'h0);
      end
    end
  end

  initial begin
    int w;
    reset     = 1'b1;
    arb_en    = 1'b0;
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
`ifdef RFARB_LOCK_EN
    req_lock  = '0;
    m_locked  = 1'b0;
    m_lock_id = 0;
`endif
    #2;
    check("rst_wr_enable", 64'(wr_enable), 64'h0);
    check("rst_wr_rd", 64'(wr_rd), 64'h0);
    check("rst_wr_data", 64'(wr_data), 64'h0);
    check("rst_grant_id", 64'(grant_id), 64'h0);
    check("rst_pending", 64'(pending), 64'h0);
    @(negedge clk);
    reset  = 1'b0;
    arb_en = 1'b1;

`ifdef RFARB_LOCK_EN
    // Requester 0 holds the port for three beats while requester 1 waits.
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      req_valid = 4'b0011;
      set_req(0, AW'(10 + k), DW'(32'hA000 + k));
      set_req(1, 5'd20, 32'hB0B0);
      req_lock  = (k < 2) ? 4'b0001 : 4'b0000;
      issue(w);
      check("lock_grant", 64'(req_ready), (k < 3) ? 64'h1 : 64'h2);
    end
    @(negedge clk);
    req_valid = '0;
    req_lock  = '0;
`endif

    // Single requester: rd=7, data=DEADBEEF from requester 1.
    @(negedge clk);
    req_valid = 4'b0010;
    set_req(1, 5'd7, 32'hDEAD_BEEF);
    issue(w);
    check("single_ready", 64'(req_ready), 64'h2);
    @(posedge clk);
    #1;
    check("single_wr_enable", 64'(wr_enable), 64'h1);
    check("single_wr_rd", 64'(wr_rd), 64'd7);
    check("single_wr_data", 64'(wr_data), 64'hDEAD_BEEF);
    check("single_grant_id", 64'(grant_id), 64'h1);
    check("single_pending", 64'(pending), 64'h80);

    // x0 write: handshake completes but nothing is written.
    @(negedge clk);
    req_valid = 4'b0100;
    set_req(2, 5'd0, 32'h55);
    issue(w);
    check("x0_ready", 64'(req_ready), 64'h4);
    @(posedge clk);
    #1;
    check("x0_wr_enable", 64'(wr_enable), 64'h0);
    check("x0_pending", 64'(pending), 64'h0);
    check("x0_wr_rd", 64'(wr_rd), 64'h0);
    check("x0_grant_id", 64'(grant_id), 64'h2);

    // arb_en low for two cycles with requester 3 valid.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_valid = 4'b1000;
      set_req(3, 5'd31, 32'h3333_0000);
      arb_en = (k == 2);
      issue(w);
      check("arb_en_ready", 64'(req_ready), (k == 2) ? 64'h8 : 64'h0);
      if (k == 1) begin
        @(posedge clk);
        #1;
        check("hold_grant_id", 64'(grant_id), 64'h2);
        check("hold_wr_data", 64'(wr_data), 64'h55);
      end
    end

    // Asynchronous reset while a write is on the port.
    @(negedge clk);
    req_valid = 4'b0001;
    set_req(0, 5'd9, 32'h1234_5678);
    issue(w);
    @(posedge clk);
    #3;
    check("pre_reset_wr_enable", 64'(wr_enable), 64'h1);
    reset     = 1'b1;
    req_valid = '0;
    m_ptr     = 0;
`ifdef RFARB_LOCK_EN
    m_locked  = 1'b0;
`endif
    #1;
    check("mid_rst_wr_enable", 64'(wr_enable), 64'h0);
    check("mid_rst_wr_rd", 64'(wr_rd), 64'h0);
    check("mid_rst_wr_data", 64'(wr_data), 64'h0);
    check("mid_rst_grant_id", 64'(grant_id), 64'h0);
    check("mid_rst_pending", 64'(pending), 64'h0);

    // All four valid from rr_ptr=0: grants rotate 0,1,2,3,0,...
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      reset     = 1'b0;
      req_valid = 4'b1111;
      for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1 + 4*(k%2)), DW'(k*16 + i));
      issue(w);
      check("rr_order", 64'(req_ready), 64'(4'b0001 << (k % 4)));
    end

    // Randomized traffic.
    for (int i = 0; i < NREQ; i++) h_valid[i] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (!h_valid[i] && $urandom_range(0, 2) == 0) begin
          h_valid[i] = 1'b1;
          h_rd[i]    = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
          h_data[i]  = $urandom;
        end
        req_valid[i] = h_valid[i];
        set_req(i, h_rd[i], h_data[i]);
`ifdef RFARB_LOCK_EN
        req_lock[i] = ($urandom_range(0, 5) == 0);
`endif
      end
      arb_en = ($urandom_range(0, 7) != 0);
      issue(w);
      if (w >= 0) h_valid[w] = 1'b0;
    end

    @(negedge clk);
    req_valid = '0;
    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
